// File: rtl/jkff_pkg.sv
// Shared definitions for the JK flip-flop monitor and related JK logic.
//   state_t  : monitor FSM states (IDLE, SYNC, TRACK, HALT)
//   HOLD/RST/SET/TGL : JK excitation opcodes, packed as {j,k}
//   jk_next  : single-bit JK characteristic equation
package jkff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] RST  = 2'b01;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] TGL  = 2'b11;

  function automatic logic jk_next(input logic j, input logic k, input logic q);
    logic r;
    case ({j, k})
      HOLD:    r = q;
      RST:     r = 1'b0;
      SET:     r = 1'b1;
      default: r = ~q;   // TGL
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_expect.sv
// Combinational N-bit JK characteristic-equation evaluator.
//   j, k   in  N  excitation per bit
//   q      in  N  present state per bit
//   q_next out N  state after the next clock edge
module jk_expect
  import jkff_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] j,
  input  logic [N-1:0] k,
  input  logic [N-1:0] q,
  output logic [N-1:0] q_next
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign q_next[i] = jk_next(j[i], k[i], q[i]);
  end

endmodule

// File: rtl/jkff_monitor.sv
// Passive checker for an N-bit JK register. Samples j/k/q on one edge and
// checks the q seen on the following edge against the JK characteristic
// equation, reporting a per-edge strobe, a sticky flag, a saturating error
// count and the failing-bit mask of the first mismatch.
//
// Ports:
//   clk        in   clock, same edge as the observed flops
//   rst        in   synchronous active-high reset
//   en         in   checking enable (0 = pause, sample discarded)
//   j, k       in   N  excitation presented to the observed flops
//   q, qbar    in   N  observed flop outputs
//   err_pulse  out  one-cycle strobe per mismatching edge
//   err_sticky out  set on the first mismatch, cleared by rst only
//   err_count  out  CW  saturating mismatch counter
//   fail_mask  out  N  mismatch vector captured at the first mismatch
//   busy       out  high while in TRACK
//
// Build option: define JKFF_MONITOR_QBAR_CHECK_EN to also check qbar == ~q
// on every tracked edge; otherwise qbar is ignored.
module jkff_monitor
  import jkff_pkg::*;
#(
  parameter int N            = 4,
  parameter int CW           = 8,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  j,
  input  logic [N-1:0]  k,
  input  logic [N-1:0]  q,
  input  logic [N-1:0]  qbar,
  output logic          err_pulse,
  output logic          err_sticky,
  output logic [CW-1:0] err_count,
  output logic [N-1:0]  fail_mask,
  output logic          busy
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t       state, state_nxt;
  logic [N-1:0] j_s, k_s, q_s;
  logic [N-1:0] exp_q;
  logic [N-1:0] qbar_bad;
  logic [N-1:0] mm;
  logic         check;
  logic         capture;
  logic         fail;

  // Expected q from the samples taken on the previous edge.
  jk_expect #(.N(N)) u_expect (
    .j      (j_s),
    .k      (k_s),
    .q      (q_s),
    .q_next (exp_q)
  );

`ifdef JKFF_MONITOR_QBAR_CHECK_EN
  always_comb begin
    qbar_bad = '0;
    for (int i = 0; i < N; i++) qbar_bad[i] = (qbar[i] !== ~q[i]);
  end
`else
  logic unused_qbar;
  assign qbar_bad    = '0;
  assign unused_qbar = ^qbar;
`endif

  // Case inequality so an X/Z on q is flagged rather than masked.
  always_comb begin
    mm = '0;
    for (int i = 0; i < N; i++) mm[i] = (q[i] !== exp_q[i]) | qbar_bad[i];
  end

  assign check   = (state == TRACK) && en;
  assign capture = ((state == SYNC) && en) || check;
  assign fail    = check && (|mm);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (en) state_nxt = SYNC;
      SYNC:  if (en) state_nxt = TRACK;
      TRACK: begin
        // Dropping en discards the pending sample; re-prime before checking.
        if (!en)                                  state_nxt = SYNC;
        else if ((STOP_ON_FAIL != 0) && (|mm))    state_nxt = HALT;
      end
      default: state_nxt = HALT;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == TRACK);
  end

  // Sample registers and error reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      j_s        <= '0;
      k_s        <= '0;
      q_s        <= '0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      fail_mask  <= '0;
    end else begin
      if (capture) begin
        j_s <= j;
        k_s <= k;
        q_s <= q;
      end
      err_pulse <= fail;
      if (fail) begin
        if (err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
        err_sticky <= 1'b1;
        if (!err_sticky) fail_mask <= mm;
      end
    end
  end

endmodule

// File: tb/tb_jkff_monitor.sv
module tb_jkff_monitor;

  localparam int N = 4;
`ifdef JKFF_MONITOR_QBAR_CHECK_EN
  localparam bit QB = 1'b1;
`else
  localparam bit QB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_i = 1'b1, en_i = 1'b0;
  logic [N-1:0] j_i = '0, k_i = '0, q_i = '0, qbar_i = '1;

  logic         p0, p1, p2, s0o, s1o, s2o, b0, b1, b2;
  logic [7:0]   c0, c2;
  logic [1:0]   c1;
  logic [N-1:0] m0, m1, m2;

  always #5 clk = ~clk;

  jkff_monitor #(.N(N), .CW(8), .STOP_ON_FAIL(0)) u_main (
    .clk(clk), .rst(rst_i), .en(en_i), .j(j_i), .k(k_i), .q(q_i), .qbar(qbar_i),
    .err_pulse(p0), .err_sticky(s0o), .err_count(c0), .fail_mask(m0), .busy(b0));
  jkff_monitor #(.N(N), .CW(2), .STOP_ON_FAIL(0)) u_sat (
    .clk(clk), .rst(rst_i), .en(en_i), .j(j_i), .k(k_i), .q(q_i), .qbar(qbar_i),
    .err_pulse(p1), .err_sticky(s1o), .err_count(c1), .fail_mask(m1), .busy(b1));
  jkff_monitor #(.N(N), .CW(8), .STOP_ON_FAIL(1)) u_stop (
    .clk(clk), .rst(rst_i), .en(en_i), .j(j_i), .k(k_i), .q(q_i), .qbar(qbar_i),
    .err_pulse(p2), .err_sticky(s2o), .err_count(c2), .fail_mask(m2), .busy(b2));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- stimulus state ----------------
  logic [N-1:0] q_true = '0;   // golden JK register driven by the bench
  logic [N-1:0] f0 = '0, f1 = '0, fqb = '0;  // stuck-at-0, stuck-at-1, qbar fault

  // ---------------- reference model (one per DUT) ----------------
  int           m_cw   [3] = '{8, 2, 8};
  bit           m_stopc[3] = '{0, 0, 1};
  bit           m_start[3], m_have[3], m_halt[3], m_pulse[3], m_sticky[3];
  int           m_count[3];
  logic [N-1:0] m_sj[3], m_sk[3], m_sq[3], m_mask[3];

  function automatic logic ref_bit(input logic jj, input logic kk, input logic qq);
    if (!jj && !kk) return qq;
    if (!jj &&  kk) return 1'b0;
    if ( jj && !kk) return 1'b1;
    return !qq;
  endfunction

  task automatic model_step(input int d);
    logic [N-1:0] e, mm;
    m_pulse[d] = 0;
    if (rst_i) begin
      m_start[d] = 0; m_have[d] = 0; m_halt[d] = 0;
      m_sticky[d] = 0; m_count[d] = 0; m_mask[d] = '0;
      return;
    end
    if (m_halt[d]) return;
    if (!m_start[d]) begin m_start[d] = en_i; return; end
    if (!en_i) begin m_have[d] = 0; return; end
    if (m_have[d]) begin
      for (int i = 0; i < N; i++) e[i] = ref_bit(m_sj[d][i], m_sk[d][i], m_sq[d][i]);
      mm = e ^ q_i;
      if (QB) mm = mm | ~(q_i ^ qbar_i);
      if (mm != '0) begin
        m_pulse[d] = 1;
        if (m_count[d] < (1 << m_cw[d]) - 1) m_count[d]++;
        if (!m_sticky[d]) m_mask[d] = mm;
        m_sticky[d] = 1;
        if (m_stopc[d]) begin m_halt[d] = 1; m_have[d] = 0; return; end
      end
    end
    m_sj[d] = j_i; m_sk[d] = k_i; m_sq[d] = q_i; m_have[d] = 1;
  endtask

  task automatic cmp_all();
    chk("u_main.pulse",  {31'd0, p0},  {31'd0, m_pulse[0]});
    chk("u_main.sticky", {31'd0, s0o}, {31'd0, m_sticky[0]});
    chk("u_main.count",  {24'd0, c0},  m_count[0]);
    chk("u_main.mask",   {28'd0, m0},  {28'd0, m_mask[0]});
    chk("u_main.busy",   {31'd0, b0},  {31'd0, m_have[0]});
    chk("u_sat.pulse",   {31'd0, p1},  {31'd0, m_pulse[1]});
    chk("u_sat.count",   {30'd0, c1},  m_count[1]);
    chk("u_sat.mask",    {28'd0, m1},  {28'd0, m_mask[1]});
    chk("u_stop.pulse",  {31'd0, p2},  {31'd0, m_pulse[2]});
    chk("u_stop.sticky", {31'd0, s2o}, {31'd0, m_sticky[2]});
    chk("u_stop.count",  {24'd0, c2},  m_count[2]);
    chk("u_stop.busy",   {31'd0, b2},  {31'd0, m_have[2]});
  endtask

  // One clock: drive inputs, clock, update model and golden flop, compare.
  task automatic cyc(input logic r, input logic e, input logic [N-1:0] jj, input logic [N-1:0] kk);
    rst_i  = r; en_i = e; j_i = jj; k_i = kk;
    q_i    = (q_true & ~f0) | f1;
    qbar_i = ~q_i ^ fqb;
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d);
    for (int i = 0; i < N; i++) q_true[i] = ref_bit(jj[i], kk[i], q_true[i]);
    #1;
    cmp_all();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic         rst, en;
    logic [N-1:0] j, k, s0, qb;
    logic         pulse;
    logic [7:0]   cnt;
    logic         sticky;
    logic [N-1:0] mask;
    logic         busy;
  } vec_t;

  vec_t tbl[26];

  initial begin
    //            rst en  j      k      s0     qb     pls cnt sti mask   busy
    tbl[0]  = '{1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0};
    tbl[1]  = '{1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0};
    tbl[2]  = '{0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0};  // 00, to SYNC
    tbl[3]  = '{0, 1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 0, 0, 4'h0, 1};  // 01, primed
    tbl[4]  = '{0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 1};  // 10
    tbl[5]  = '{0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 1};  // 00
    tbl[6]  = '{0, 1, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0, 0, 4'h0, 1};  // 11
    tbl[7]  = '{0, 1, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0, 0, 4'h0, 1};  // 11
    tbl[8]  = '{0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 1};
    tbl[9]  = '{0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 1};
    tbl[10] = '{0, 1, 4'hF, 4'h0, 4'h4, 4'h0, 1, 1, 1, 4'h4, 1};  // q[2] stuck 0
    tbl[11] = '{0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 1, 1, 4'h4, 1};
    tbl[12] = '{0, 1, 4'hF, 4'h0, 4'h5, 4'h0, 1, 2, 1, 4'h4, 1};  // bits 0,2
    tbl[13] = '{0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 2, 1, 4'h4, 1};
    tbl[14] = '{0, 0, 4'h0, 4'h0, 4'hF, 4'h0, 0, 2, 1, 4'h4, 0};  // pause, corrupt q
    tbl[15] = '{0, 0, 4'h0, 4'h0, 4'hF, 4'h0, 0, 2, 1, 4'h4, 0};
    tbl[16] = '{0, 0, 4'h0, 4'h0, 4'hF, 4'h0, 0, 2, 1, 4'h4, 0};
    tbl[17] = '{0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 2, 1, 4'h4, 1};  // re-sync
    tbl[18] = '{0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 2, 1, 4'h4, 1};
    tbl[19] = '{1, 1, 4'h0, 4'h0, 4'h1, 4'h0, 0, 0, 0, 4'h0, 0};  // rst beats mismatch
    tbl[20] = '{0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0};
    tbl[21] = '{1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0};
    tbl[22] = '{0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0};
    tbl[23] = '{0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 1};
    tbl[24] = '{0, 1, 4'h0, 4'h0, 4'h0, 4'h2, QB, 8'(QB), QB, QB ? 4'h2 : 4'h0, 1}; // qbar[1]=q[1]
    tbl[25] = '{0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'(QB), QB, QB ? 4'h2 : 4'h0, 0};

    for (int d = 0; d < 3; d++) begin
      m_start[d] = 0; m_have[d] = 0; m_halt[d] = 0; m_pulse[d] = 0;
      m_sticky[d] = 0; m_count[d] = 0; m_mask[d] = '0;
      m_sj[d] = '0; m_sk[d] = '0; m_sq[d] = '0;
    end

    for (int r = 0; r < 26; r++) begin
      f0 = tbl[r].s0; f1 = '0; fqb = tbl[r].qb;
      cyc(tbl[r].rst, tbl[r].en, tbl[r].j, tbl[r].k);
      chk($sformatf("tbl%0d.pulse", r),  {31'd0, p0},  {31'd0, tbl[r].pulse});
      chk($sformatf("tbl%0d.count", r),  {24'd0, c0},  {24'd0, tbl[r].cnt});
      chk($sformatf("tbl%0d.sticky", r), {31'd0, s0o}, {31'd0, tbl[r].sticky});
      chk($sformatf("tbl%0d.mask", r),   {28'd0, m0},  {28'd0, tbl[r].mask});
      chk($sformatf("tbl%0d.busy", r),   {31'd0, b0},  {31'd0, tbl[r].busy});
    end
    f0 = '0; fqb = '0;

    // Saturation: q[0] stuck at 1 while every bit is driven with RST.
    cyc(1, 0, 4'h0, 4'h0);
    q_true = '0; f1 = 4'h1;
    cyc(0, 1, 4'h0, 4'hF);
    cyc(0, 1, 4'h0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 4'h0, 4'hF);
      chk("sat.pulse", {31'd0, p1}, 32'd1);
      chk("sat.count", {30'd0, c1}, (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      chk("sat.main_count", {24'd0, c0}, 32'(i + 1));
    end
    chk("stop.halted_count", {24'd0, c2}, 32'd1);
    chk("stop.halted_busy",  {31'd0, b2}, 32'd0);
    f1 = '0;

    // Randomized run against the model.
    cyc(1, 0, 4'h0, 4'h0);
    for (int n = 0; n < 800; n++) begin
      f0  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      f1  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
      fqb = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'h0;
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0, 4'($urandom), 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jkff_monitor.md
# jkff_monitor

Passive checker at the observing end of a JK flip-flop bank: samples the J/K excitation driven into an N-bit JK register together with the register's Q/QBAR outputs, and verifies each clock edge against the JK characteristic equation. It sits beside any JK-based register, in simulation benches or as a built-in self-check. It reports per-cycle mismatches, a sticky fault flag, a saturating error count and first-failure capture.

## Interface
- N, 4: number of JK bits observed
- CW, 8: error counter width
- STOP_ON_FAIL, 0: 1 = freeze checking after the first mismatch
- clk  in  1  clock; same edge that clocks the observed flops
- rst  in  1  synchronous, active-high reset
- en  in  1  checking enable; 0 = pause, no samples taken
- j  in  N  J inputs as presented to the observed flops
- k  in  N  K inputs as presented to the observed flops
- q  in  N  observed Q outputs
- qbar  in  N  observed QBAR outputs
- err_pulse  out  1  one-cycle strobe per mismatching edge
- err_sticky  out  1  set on first mismatch, cleared only by rst
- err_count  out  CW  mismatching edges, saturates at all-ones
- fail_mask  out  N  bits that failed at the first mismatch
- busy  out  1  1 in TRACK state

## Operation
- Reset is synchronous and active-high. Every output resets to 0, and the FSM resets to IDLE.
- FSM states:
  - IDLE -> SYNC when en=1.
  - SYNC: capture j, k and q into sample registers, then go to TRACK.
  - TRACK: each edge with en=1, compute expected = (j_s & ~q_s) | (~k_s & q_s) per bit, compare it with the current q, then re-capture j, k and q.
  - TRACK with en=0 -> SYNC; the next enabled edge re-primes and does not check stale samples.
  - TRACK -> HALT on a mismatch when STOP_ON_FAIL=1. HALT exits only via rst.
- Mismatch: any bit with q != expected.
  - err_pulse is high for that one cycle.
  - err_count increments by 1. At all-ones it holds with no wrap.
  - err_sticky is set.
  - fail_mask is loaded with the mismatch vector, only if err_sticky was 0.
- Characteristic equation cases, all four required:
  - 00 hold
  - 01 reset to 0
  - 10 set to 1
  - 11 toggle
- X/Z on q counts as a mismatch; the comparison uses !==.
- The monitor never drives the observed flops.

## Timing
- Checking latency: the mismatch is flagged one edge after the edge that caused it. Samples taken at edge n are checked against q at edge n+1; err_pulse is registered and asserts after edge n+1.
- The first check happens on the second enabled edge after leaving IDLE.
- Simultaneous rst and mismatch: rst wins. No count, no flag.
- en deasserted mid-check: the pending sample is discarded and no check is performed.
- err_count is at saturation (2^CW-1) and another mismatch occurs: the count holds, and err_pulse still fires.

## Configuration
- JKFF_MONITOR_QBAR_CHECK_EN defined: on every TRACK edge the monitor also checks qbar == ~q. A failing bit is ORed into the mismatch vector, so it feeds the same err_pulse, count and mask.
- Macro undefined: the qbar port is present but ignored, and the check logic is not compiled.

## Structure
- Shared package jkff_pkg holds:
  - the state enum (IDLE, SYNC, TRACK, HALT);
  - the JK opcode constants (HOLD=2'b00, RST=2'b01, SET=2'b10, TGL=2'b11);
  - the function jk_next(j, k, q).
- One sub-module, jk_expect, is natural: a combinational N-bit characteristic-equation evaluator. It is reused by future JK counters.
- The top level holds the FSM, sample registers, comparator, counter and capture logic.

## Test plan
- Reset: rst=1 for 2 edges -> all outputs 0, FSM in IDLE, busy=0.
- Legal sequence on a golden JK model (N=4), en=1: apply jk=00, 01, 10, 00, 11, 11 on all bits -> err_count=0, err_sticky=0, busy=1 from the second edge.
- Fault injection: force q[2] stuck at 0 while bit 2 gets j=1, k=0 -> err_pulse is high for exactly one cycle one edge later, err_count=1, fail_mask=4'b0100. Then fault bit 0 as well -> fail_mask unchanged, err_count=2.
- Saturation: CW=2 with a permanent fault held for 6 edges -> err_count stops at 3, err_pulse high on every checked edge.
- Pause and reset: en=0 for 3 edges while q is corrupted, then en=1 -> no errors counted during the pause or on the re-sync edge. rst asserted on a mismatching edge -> err_sticky=0.
- Macro on: JKFF_MONITOR_QBAR_CHECK_EN defined, drive qbar[1]=q[1] -> mismatch with fail_mask=4'b0010. Macro off, same stimulus -> no error.
